mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// M-stage data memory access unit: issues one aligned bus transaction per load/store,
// stalls the pipeline while it is outstanding and hands the result to a registered W stage.
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  strCtrlM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUoutM,
  input  logic [31:0] r2M,
  input  logic [4:0]  rdM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stallM,
  output logic        misalignM,
  output logic        busErrM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ALUoutW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  rdW
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          berr_q, berr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          regw_q, regw_d;
  logic          m2r_q, m2r_d;
  logic [31:0]   alu_q, alu_d;
  logic [31:0]   rdd_q, rdd_d;
  logic [4:0]    rdw_q, rdw_d;

  logic        access, is_ld, fault, bad_sz, sz_byte, sz_half, sz_word;
  logic [1:0]  a;
  logic [3:0]  be;
  logic [31:0] wdata, ld_ext;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // A store flag wins when both control bits are set.
  assign access  = MemWriteM | MemtoRegM;
  assign is_ld   = MemtoRegM & ~MemWriteM;
  assign a       = ALUoutM[1:0];
  assign bad_sz  = (strCtrlM == 3'b011) | (strCtrlM == 3'b110) | (strCtrlM == 3'b111);
  assign sz_byte = (strCtrlM[1:0] == 2'b00);
  assign sz_half = (strCtrlM[1:0] == 2'b01);
  assign sz_word = (strCtrlM == 3'b010);
  assign fault   = access & (bad_sz | (sz_half & a[0]) | (sz_word & (a != 2'b00)));

  always_comb begin
    be    = 4'b1111;
    wdata = r2M;
    if (sz_byte) begin
      be    = 4'b0001 << a;
      wdata = {4{r2M[7:0]}};
    end else if (sz_half) begin
      be    = 4'b0011 << {a[1], 1'b0};
      wdata = {2{r2M[15:0]}};
    end
  end

  assign ld_b = 8'(dmem_rdata >> {a, 3'b000});
  assign ld_h = 16'(dmem_rdata >> {a[1], 4'b0000});

  always_comb begin
    case (strCtrlM)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_ext = {24'b0, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_ext = {16'b0, ld_h};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // Bus side is only driven while a request is outstanding.
  assign dmem_req   = (state_q == BUSY);
  assign dmem_we    = dmem_req & MemWriteM;
  assign dmem_be    = dmem_req ? be : 4'b0000;
  assign dmem_addr  = dmem_req ? {ALUoutM[31:2], 2'b00} : 32'b0;
  assign dmem_wdata = dmem_req ? wdata : 32'b0;

  // The abort cycle (berr_q) releases the stall so the dead instruction leaves M.
  assign stallM    = (state_q == BUSY) |
                     (rst & (state_q == IDLE) & ~berr_q & access & ~fault);
  assign misalignM = rst & (state_q == IDLE) & ~berr_q & fault;
  assign busErrM   = berr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    berr_d  = 1'b0;
    rdata_d = rdata_q;
    regw_d  = 1'b0;
    m2r_d   = 1'b0;
    alu_d   = 32'b0;
    rdd_d   = 32'b0;
    rdw_d   = 5'b0;
    case (state_q)
      IDLE: begin
        if (!berr_q && !access) begin
          regw_d = RegWriteM;
          alu_d  = ALUoutM;
          rdw_d  = rdM;
        end else if (!berr_q && !fault) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          rdata_d = is_ld ? ld_ext : 32'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          berr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        regw_d  = RegWriteM;
        m2r_d   = is_ld;
        alu_d   = ALUoutM;
        rdd_d   = rdata_q;
        rdw_d   = rdM;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
      rdata_q <= 32'b0;
      regw_q  <= 1'b0;
      m2r_q   <= 1'b0;
      alu_q   <= 32'b0;
      rdd_q   <= 32'b0;
      rdw_q   <= 5'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
      rdata_q <= rdata_d;
      regw_q  <= regw_d;
      m2r_q   <= m2r_d;
      alu_q   <= alu_d;
      rdd_q   <= rdd_d;
      rdw_q   <= rdw_d;
    end
  end

  assign RegWriteW = regw_q;
  assign MemtoRegW = m2r_q;
  assign ALUoutW   = alu_q;
  assign ReadDataW = rdd_q;
  assign rdW       = rdw_q;

endmodule
